mem_access: RTL

Memory-access stage of the RV32 pipeline, directly downstream of the execute stage. It takes the registered ALU result, store data, branch target and zero flag from execute. For loads and stores it runs a request/acknowledge transaction on the data-memory bus, aligning store data and extracting loaded data. It then presents a single registered result to writeback and stalls upstream while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access stage: aligns stores, extracts loads, runs the dmem req/ack handshake
// and presents one registered writeback result per instruction.
module mem_access #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_w,
  input  logic        zero,
  input  logic [31:0] PC_sum,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic        branch,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        misalign_fault,
  output logic        bus_fault
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        req_n, we_n, wb_valid_n, wb_rw_n, pc_src_n, mis_n, bf_n;
  logic [31:0] addr_n, wdata_n, wb_data_n, bt_n;
  logic [3:0]  be_n;
  logic [4:0]  wb_rd_n;
  // Pending-access context kept for load extraction and the writeback of the held instruction
  logic [1:0]  p_off, p_off_n;
  logic [2:0]  p_f3, p_f3_n;
  logic        p_load, p_load_n, p_rw, p_rw_n;
  logic [4:0]  p_rd, p_rd_n;

  logic        legal;
  logic [1:0]  off;
  logic [3:0]  be_st;
  logic [31:0] wd_st, shifted, ext;

  assign stall = (state == BUS);
  assign off   = alu_result[1:0];

  always_comb begin
    legal = 1'b0;
    be_st = 4'b1111;
    wd_st = rs2_w;
    unique case (funct3[1:0])
      2'b00: begin legal = 1'b1;        be_st = 4'b0001 << off; wd_st = {4{rs2_w[7:0]}};  end
      2'b01: begin legal = !off[0];     be_st = 4'b0011 << off; wd_st = {2{rs2_w[15:0]}}; end
      2'b10: begin legal = (off == 2'b00); end
      default: legal = 1'b0;
    endcase
    if (mem_write && funct3[2]) legal = 1'b0;
  end

  always_comb begin
    shifted = dmem_rdata >> {p_off, 3'b000};
    unique case (p_f3[1:0])
      2'b00:   ext = {{24{!p_f3[2] && shifted[7]}},  shifted[7:0]};
      2'b01:   ext = {{16{!p_f3[2] && shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_n      = dmem_req;
    we_n       = dmem_we;
    addr_n     = dmem_addr;
    wdata_n    = dmem_wdata;
    be_n       = dmem_be;
    wb_valid_n = 1'b0;
    wb_data_n  = wb_data;
    wb_rd_n    = wb_rd;
    wb_rw_n    = 1'b0;
    pc_src_n   = 1'b0;
    bt_n       = branch_target;
    mis_n      = 1'b0;
    bf_n       = 1'b0;
    p_off_n    = p_off;
    p_f3_n     = p_f3;
    p_load_n   = p_load;
    p_rw_n     = p_rw;
    p_rd_n     = p_rd;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          bt_n    = PC_sum;
          wb_rd_n = rd_in;
          if (!(mem_read || mem_write)) begin
            wb_valid_n = 1'b1;
            wb_data_n  = alu_result;
            wb_rw_n    = reg_write_in;
            pc_src_n   = branch && zero;
          end else if (!legal) begin
            wb_valid_n = 1'b1;
            wb_data_n  = alu_result;
            mis_n      = 1'b1;
          end else begin
            state_n  = BUS;
            cnt_n    = '0;
            req_n    = 1'b1;
            we_n     = mem_write;
            addr_n   = {alu_result[31:2], 2'b00};
            be_n     = mem_write ? be_st : 4'b0000;
            wdata_n  = mem_write ? wd_st : '0;
            p_off_n  = off;
            p_f3_n   = funct3;
            p_load_n = !mem_write;
            p_rw_n   = reg_write_in;
            p_rd_n   = rd_in;
          end
        end
      end
      BUS: begin
        // An ack arriving in the timeout cycle completes normally
        if (dmem_ack) begin
          state_n    = IDLE;
          req_n      = 1'b0;
          wb_valid_n = 1'b1;
          wb_rd_n    = p_rd;
          wb_rw_n    = p_load && p_rw;
          wb_data_n  = p_load ? ext : {dmem_addr[31:2], p_off};
        end else if (cnt == 16'(MAX_WAIT - 1)) begin
          state_n    = IDLE;
          req_n      = 1'b0;
          wb_valid_n = 1'b1;
          wb_rd_n    = p_rd;
          wb_data_n  = {dmem_addr[31:2], p_off};
          bf_n       = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      pc_src         <= 1'b0;
      branch_target  <= '0;
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
      p_off          <= '0;
      p_f3           <= '0;
      p_load         <= 1'b0;
      p_rw           <= 1'b0;
      p_rd           <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      dmem_req       <= req_n;
      dmem_we        <= we_n;
      dmem_addr      <= addr_n;
      dmem_wdata     <= wdata_n;
      dmem_be        <= be_n;
      wb_valid       <= wb_valid_n;
      wb_data        <= wb_data_n;
      wb_rd          <= wb_rd_n;
      wb_reg_write   <= wb_rw_n;
      pc_src         <= pc_src_n;
      branch_target  <= bt_n;
      misalign_fault <= mis_n;
      bus_fault      <= bf_n;
      p_off          <= p_off_n;
      p_f3           <= p_f3_n;
      p_load         <= p_load_n;
      p_rw           <= p_rw_n;
      p_rd           <= p_rd_n;
    end
  end

endmodule
